fx2_slave_fifo_model: RTL

Synthesizable model of the Cypress FX2 slave-FIFO endpoint pair, i.e. the chip side of the FX2 interface that the FPGA comm core drives. It exposes EP2 (host→FPGA, OUT) and EP6 (FPGA→host, IN) FIFOs to a host-side stream port. It generates FLAGx and FDI and responds to SLRD, SLWR, SLOE, ADDR and PKTEND. It is used for on-chip loopback and for co-simulation benches, which then need no external FX2 BFM.

---
 rtl/fx2_pkg.sv | 19 +
 rtl/fx2_ep_fifo.sv | 72 +++++++
 rtl/fx2_slave_fifo_model.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO model: endpoint addresses, size defaults
// and the bit positions of FLAGA..FLAGD inside the packed flag register.
package fx2_pkg;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP6_ADDR = 2'b10;

    localparam int DEPTH_LOG2_DEFAULT = 10;
    localparam int PKT_SIZE_DEFAULT   = 512;

    localparam int FLAGA_BIT = 0;
    localparam int FLAGB_BIT = 1;
    localparam int FLAGC_BIT = 2;
    localparam int FLAGD_BIT = 3;

    // FLAGA and FLAGD are constant 1; FLAGB and FLAGC come up 0 out of reset.
    localparam logic [3:0] FLAGS_RESET = 4'b1001;

endpackage

// File: rtl/fx2_ep_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count. Pointers are exposed
// so a wrapper can keep per-entry sideband state (EP6 last bits) alongside the data.
module fx2_ep_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2-1:0] wr_ptr,
    output logic [DEPTH_LOG2-1:0] rd_ptr
);

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    // A push to a full FIFO is dropped even when a pop happens in the same cycle.
    always_comb begin
        full     = (count_q == DEPTH);
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;
    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;

endmodule

// File: rtl/fx2_slave_fifo_model.sv
// Chip side of the FX2 slave-FIFO interface: EP2 (host->FPGA) and EP6 (FPGA->host, packetised).
// Define FX2_SLAVE_FIFO_CHECK_EN to enable the sticky protocol-violation flag on err.
module fx2_slave_fifo_model
    import fx2_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int PKT_SIZE   = PKT_SIZE_DEFAULT
) (
    input  logic       IFCLK,
    input  logic       RST,
    input  logic       SLRD,
    input  logic       SLWR,
    input  logic       SLOE,
    input  logic [7:0] FDO,
    input  logic       FDS,
    input  logic [1:0] ADDR,
    input  logic       PKTEND,
    output logic [7:0] FDI,
    output logic       FLAGA,
    output logic       FLAGB,
    output logic       FLAGC,
    output logic       FLAGD,
    input  logic [7:0] h_out_data,
    input  logic       h_out_valid,
    output logic       h_out_ready,
    output logic [7:0] h_in_data,
    output logic       h_in_last,
    output logic       h_in_valid,
    input  logic       h_in_ready,
    output logic       err
);

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   PKT_CNT = (DEPTH_LOG2+1)'(PKT_SIZE);

    logic [7:0]            ep2_head;
    logic [DEPTH_LOG2:0]   ep2_count, ep2_count_next;
    logic                  ep2_full, ep2_empty;
    logic [DEPTH_LOG2-1:0] ep2_wr_ptr, ep2_rd_ptr;
    logic                  ep2_push, ep2_pop;

    logic [7:0]            ep6_head;
    logic [DEPTH_LOG2:0]   ep6_count, ep6_count_next;
    logic                  ep6_full, ep6_empty;
    logic [DEPTH_LOG2-1:0] ep6_wr_ptr, ep6_rd_ptr, ep6_newest;
    logic                  ep6_wr, ep6_pop, ep6_commit;
    logic [DEPTH_LOG2:0]   ep6_committed, uc_wr;
    logic                  last_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2:0]   uc_q, uc_d;
    logic [3:0]            flags_q, flags_d;
    logic                  h_out_ready_q, h_out_ready_d;
    logic                  err_q, err_d;
    logic                  ep_unused;

    fx2_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_ep2 (
        .clk(IFCLK), .rst(RST), .push(ep2_push), .push_data(h_out_data), .pop(ep2_pop),
        .head(ep2_head), .count(ep2_count), .count_next(ep2_count_next), .full(ep2_full),
        .empty(ep2_empty), .wr_ptr(ep2_wr_ptr), .rd_ptr(ep2_rd_ptr)
    );

    fx2_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_ep6 (
        .clk(IFCLK), .rst(RST), .push(ep6_wr), .push_data(FDO), .pop(ep6_pop),
        .head(ep6_head), .count(ep6_count), .count_next(ep6_count_next), .full(ep6_full),
        .empty(ep6_empty), .wr_ptr(ep6_wr_ptr), .rd_ptr(ep6_rd_ptr)
    );

    assign ep_unused = ^{ep2_count, ep2_full, ep2_wr_ptr, ep2_rd_ptr, ep6_empty};

    // EP6 entries between the commit point and the write pointer stay invisible to the host.
    always_comb begin
        ep2_pop       = !SLRD && (ADDR == EP2_ADDR);
        ep2_push      = h_out_valid && h_out_ready_q;
        ep6_wr        = !SLWR && (ADDR == EP6_ADDR) && !ep6_full;
        ep6_committed = ep6_count - uc_q;
        ep6_pop       = (ep6_committed != '0) && h_in_ready;
        uc_wr         = ep6_wr ? uc_q + CNT_ONE : uc_q;
        ep6_commit    = (uc_wr != '0) &&
                        ((!PKTEND && (ADDR == EP6_ADDR)) || (uc_wr == PKT_CNT));
        ep6_newest    = ep6_wr ? ep6_wr_ptr : ep6_wr_ptr - PTR_ONE;
        uc_d          = ep6_commit ? '0 : uc_wr;
        flags_d            = FLAGS_RESET;
        flags_d[FLAGB_BIT] = (ep6_count_next != DEPTH);
        flags_d[FLAGC_BIT] = (ep2_count_next != '0);
        h_out_ready_d      = (ep2_count_next != DEPTH);
    end

`ifdef FX2_SLAVE_FIFO_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (!SLRD && (ep2_empty || (ADDR != EP2_ADDR))) err_d = 1'b1;
        if (!SLWR && (ep6_full || (ADDR != EP6_ADDR) || !FDS)) err_d = 1'b1;
        if (!SLRD && !SLWR) err_d = 1'b1;
        if (!PKTEND && (ADDR != EP6_ADDR)) err_d = 1'b1;
    end
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge IFCLK or posedge RST) begin
        if (RST) begin
            uc_q          <= '0;
            flags_q       <= FLAGS_RESET;
            h_out_ready_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            uc_q          <= uc_d;
            flags_q       <= flags_d;
            h_out_ready_q <= h_out_ready_d;
            err_q         <= err_d;
        end
    end

    // A new byte clears any stale last bit; a commit without a write marks the previous byte.
    always_ff @(posedge IFCLK) begin
        if (ep6_wr || ep6_commit) begin
            last_mem[ep6_newest] <= ep6_commit;
        end
    end

    assign FDI         = (!SLOE && (ADDR == EP2_ADDR) && !FDS && !ep2_empty) ? ep2_head : 8'h00;
    assign FLAGA       = flags_q[FLAGA_BIT];
    assign FLAGB       = flags_q[FLAGB_BIT];
    assign FLAGC       = flags_q[FLAGC_BIT];
    assign FLAGD       = flags_q[FLAGD_BIT];
    assign h_out_ready = h_out_ready_q;
    assign h_in_valid  = (ep6_committed != '0);
    assign h_in_data   = h_in_valid ? ep6_head : 8'h00;
    assign h_in_last   = h_in_valid && last_mem[ep6_rd_ptr];
    assign err         = err_q;

endmodule
